// File: rtl/divider.sv
// divider: iterative 32-bit restoring divider for MIPS DIV/DIVU.
// Produces one quotient bit per cycle (MSB first) over 32 cycles, then
// sign-corrects quotient (LO) and remainder (HI) on the way out.
module divider (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div,
  input  logic        div_signed,
  input  logic [31:0] div_operand1,
  input  logic [31:0] div_operand2,
  input  logic        div_cancel,
  output logic        div_busy,
  output logic        div_complete,
  output logic [31:0] div_quotient,
  output logic [31:0] div_remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Iteration counter: 0..31 while running.
  logic [5:0]  r_count;
  // Shift register: dividend magnitude bits leave at the top while
  // quotient bits enter at the bottom, so after 32 steps it holds the quotient.
  logic [31:0] r_quot;
  // Partial remainder; always below the divisor magnitude, so 32 bits suffice
  // once the shifted-in bit is accounted for in the 33-bit trial subtraction.
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic        r_quot_neg;
  logic        r_rem_neg;

  logic        w_start;
  logic        w_step;
  logic        w_last;
  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;
  logic [32:0] w_shifted;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_next;
  logic [31:0] w_quot_next;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  // Operand magnitudes: only signed operands with the sign bit set are negated.
  assign w_op1_mag = (div_signed && div_operand1[31]) ? (~div_operand1 + 32'd1) : div_operand1;
  assign w_op2_mag = (div_signed && div_operand2[31]) ? (~div_operand2 + 32'd1) : div_operand2;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  assign w_shifted   = {r_rem, r_quot[31]};
  assign w_diff      = w_shifted - {1'b0, r_divisor};
  assign w_qbit      = ~w_diff[32];
  assign w_rem_next  = w_diff[32] ? w_shifted[31:0] : w_diff[31:0];
  assign w_quot_next = {r_quot[30:0], w_qbit};

  // Sign fix-up applied to the final step's results.
  assign w_quot_fix = r_quot_neg ? (~w_quot_next + 32'd1) : w_quot_next;
  assign w_rem_fix  = r_rem_neg  ? (~w_rem_next  + 32'd1) : w_rem_next;

  assign w_step = (r_state == S_RUN) && !div_cancel;
  assign w_last = w_step && (r_count == 6'd31);

  // Status outputs are pure decodes of the state register.
  assign div_busy     = (r_state == S_RUN);
  assign div_complete = (r_state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; cancel outranks a start and aborts a running divide.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (div && !div_cancel) begin
          w_start      = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (div_cancel) begin
          w_state_next = S_IDLE;
        end else if (r_count == 6'd31) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (div && !div_cancel) begin
          w_start      = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on start, iterate while running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count    <= 6'd0;
      r_quot     <= 32'd0;
      r_rem      <= 32'd0;
      r_divisor  <= 32'd0;
      r_quot_neg <= 1'b0;
      r_rem_neg  <= 1'b0;
    end else if (w_start) begin
      r_count    <= 6'd0;
      r_quot     <= w_op1_mag;
      r_rem      <= 32'd0;
      r_divisor  <= w_op2_mag;
      // A zero divisor yields all-ones regardless of dividend sign, so the
      // quotient is never negated in that case.
      r_quot_neg <= div_signed && (div_operand1[31] ^ div_operand2[31]) &&
                    (div_operand2 != 32'd0);
      r_rem_neg  <= div_signed && div_operand1[31];
    end else if (w_step) begin
      r_count <= r_count + 6'd1;
      r_quot  <= w_quot_next;
      r_rem   <= w_rem_next;
    end
  end

  // Result registers: updated only on the final iteration, held otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_quotient  <= 32'd0;
      div_remainder <= 32'd0;
    end else if (w_last) begin
      div_quotient  <= w_quot_fix;
      div_remainder <= w_rem_fix;
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops on each div_complete and compares.
module tb_divider;

  logic        clk;
  logic        resetn;
  logic        div;
  logic        div_signed;
  logic [31:0] div_operand1;
  logic [31:0] div_operand2;
  logic        div_cancel;
  logic        div_busy;
  logic        div_complete;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  divider dut (
    .clk          (clk),
    .resetn       (resetn),
    .div          (div),
    .div_signed   (div_signed),
    .div_operand1 (div_operand1),
    .div_operand2 (div_operand2),
    .div_cancel   (div_cancel),
    .div_busy     (div_busy),
    .div_complete (div_complete),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && div_complete) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_complete: got complete=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check32("quotient", div_quotient, e.q);
        check32("remainder", div_remainder, e.r);
        check32("latency", cyc - e.start, 32'd33);
        check32("busy_at_complete", {31'd0, div_busy}, 32'd0);
        $display("txn done cycle %0d: q=%h r=%h (start %0d)", cyc, div_quotient, div_remainder, e.start);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start pulse; caller is 1 time unit after a rising edge.
  task automatic start_raw(input logic sg, input logic [31:0] a, input logic [31:0] b);
    div          = 1'b1;
    div_signed   = sg;
    div_operand1 = a;
    div_operand2 = b;
    wait_cycles(1);
    div = 1'b0;
  endtask

  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    e.q     = eq;
    e.r     = er;
    e.start = cyc;
    sb.push_back(e);
    $display("txn start cycle %0d: signed=%0d %h / %h", cyc, sg, a, b);
    start_raw(sg, a, b);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      wait_cycles(1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    resetn       = 1'b0;
    div          = 1'b0;
    div_signed   = 1'b0;
    div_operand1 = 32'd0;
    div_operand2 = 32'd0;
    div_cancel   = 1'b0;
    #2;
    check32("reset_quotient", div_quotient, 32'd0);
    check32("reset_remainder", div_remainder, 32'd0);
    check32("reset_busy", {31'd0, div_busy}, 32'd0);
    check32("reset_complete", {31'd0, div_complete}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_cycles(2);

    // Unsigned 100/7 with busy window check across cycles 1..33.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    for (int i = 1; i <= 33; i++) begin
      check32($sformatf("busy_c%0d", i), {31'd0, div_busy}, (i <= 32) ? 32'd1 : 32'd0);
      wait_cycles(1);
    end
    wait_drain();

    // Directed signed/unsigned and boundary vectors.
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    wait_drain();
    issue(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    wait_drain();
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    wait_drain();
    issue(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    wait_drain();
    issue(1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
    wait_drain();
    issue(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
    wait_drain();
    issue(1'b0, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 32'd15);
    wait_drain();

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
    wait_cycles(32);
    issue(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
    wait_drain();

    // Start while busy is ignored.
    issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0);
    wait_cycles(4);
    start_raw(1'b1, 32'd1000, 32'd3);
    wait_drain();

    // Cancel mid-run: no completion, outputs hold.
    start_raw(1'b0, 32'd9, 32'd4);
    wait_cycles(9);
    div_cancel = 1'b1;
    wait_cycles(1);
    div_cancel = 1'b0;
    check32("cancel_busy", {31'd0, div_busy}, 32'd0);
    check32("cancel_hold_q", div_quotient, 32'd10);
    check32("cancel_hold_r", div_remainder, 32'd0);
    wait_cycles(40);
    check32("cancel_hold_q_late", div_quotient, 32'd10);

    // Cancel together with start drops the start.
    div_cancel = 1'b1;
    start_raw(1'b0, 32'd8, 32'd2);
    div_cancel = 1'b0;
    check32("cancel_blocks_start", {31'd0, div_busy}, 32'd0);
    wait_cycles(40);

    // Asynchronous reset mid-run clears everything immediately.
    start_raw(1'b0, 32'd100, 32'd7);
    wait_cycles(9);
    #2;
    resetn = 1'b0;
    #1;
    check32("rst_q", div_quotient, 32'd0);
    check32("rst_r", div_remainder, 32'd0);
    check32("rst_busy", {31'd0, div_busy}, 32'd0);
    check32("rst_complete", {31'd0, div_complete}, 32'd0);
    wait_cycles(2);
    resetn = 1'b1;
    wait_cycles(40);
    check32("post_rst_q", div_quotient, 32'd0);

    // Recovery after reset.
    issue(1'b0, 32'd81, 32'd9, 32'd9, 32'd0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
